ram_sync: RTL and testbench
===========================

Name: ram_sync

Overview:
- Parametrised synchronous SRAM, WIDTH bits x DEPTH words. Successor to the 8x8 latch-based memory.
- Replaces level-sensitive bytecell storage with clocked storage, a registered read port with valid flag, and a request/ready handshake.
- Includes an automatic clear sequencer that zeroes the array after reset or on command.
- Sits as the general-purpose storage block under the datapath.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 8, number of words (>= 2; need not be a power of two).
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
- CLR_VAL, 0, WIDTH-bit value written to every word during clear.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- inp  input  WIDTH  write data.
- addr  input  ADDR_W  word address.
- op  input  1  1 = write, 0 = read.
- sel  input  1  request valid.
- clr  input  1  single-cycle pulse; starts a clear sequence.
- ready  output  1  block accepts a request this cycle.
- outp  output  WIDTH  registered read data.
- outp_valid  output  1  one-cycle pulse; outp holds fresh read data.
- err  output  1  one-cycle pulse; the previous request's address was >= DEPTH.
- busy  output  1  clear sequence in progress.

Behaviour:
- Reset (async, rst=1): state=CLEAR, clear counter=0, outp=0, outp_valid=0, err=0, ready=0, busy=1. Array contents are undefined until the clear completes.
- Outputs are registered. ready = (state==IDLE); busy = (state==CLEAR).
- Request accepted on a rising edge with sel & ready. With sel=0, op/addr/inp are don't-care.
- Write (op=1, addr<DEPTH): mem[addr] <= inp at the accepting edge. outp and outp_valid unchanged.
- Read (op=0, addr<DEPTH): outp <= mem[addr] at the accepting edge. outp_valid=1 for exactly the following cycle.
- Read latency: 1 cycle. Back-to-back requests are allowed every cycle, giving throughput of 1 request per cycle.
- Read-after-write to the same address on the next cycle returns the new data. No write-through is needed, because write and read occur on different edges.
- outp holds its last read value until the next accepted read.
- Out of range (addr >= DEPTH, possible only when DEPTH is not a power of two):
  - Write is discarded; the array is unchanged.
  - Read sets outp=0 and outp_valid=1.
  - Either case pulses err=1 for one cycle alongside.
- FSM:
  - CLEAR: one word per cycle, mem[cnt] <= CLR_VAL, cnt increments. When cnt==DEPTH-1, the word is written and the state moves to IDLE; cnt resets to 0. The sequence takes exactly DEPTH cycles; ready rises on the edge after the last word is cleared.
  - IDLE: clr=1 moves to CLEAR at the next edge.
- clr together with an accepted request in IDLE: the request executes first (read result and valid still delivered on the next cycle), and CLEAR begins at the same edge.
- clr while in CLEAR: ignored; the sequence is not restarted.
- sel while ready=0: ignored silently; no err, no valid.
- rst asserted mid-clear or mid-read: immediate return to the reset values above. The clear restarts from word 0 after rst deasserts, and any pending outp_valid is lost.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package ram_pkg:
  - state enum {ST_CLEAR, ST_IDLE}
  - op encoding constants OP_READ=0, OP_WRITE=1
  - clog2 helper function
- Sub-module ram_array:
  - Pure storage: clocked write port (we, waddr, wdata) and clocked read port (re, raddr, rdata).
  - No reset on the array itself.
  - The top level muxes clear-sequencer vs. request onto the write port.

Test Plan:
1. Reset, WIDTH=8 DEPTH=8 -> busy=1, ready=0 for 8 cycles; then ready=1. Read all 8 addresses -> outp=0x00 each, outp_valid pulse 1 cycle after each request.
2. Write 0xA5@3, next cycle read @3, next cycle read @4 -> outp=0xA5 with valid on the cycle after the first read, then 0x00; err never set.
3. Streaming: write addr i with value i*17 for i=0..7 on consecutive cycles, then 8 consecutive reads -> 8 consecutive valid pulses, data 0x00,0x11,..0x77 in order.
4. DEPTH=5 WIDTH=16: write 0xBEEF@6, read @6 -> err pulses twice, read returns outp=0 with valid. Read @0..4 confirms no corruption.
5. Fill array with 0xFF, pulse clr together with a read @2 -> outp=0xFF valid next cycle, busy=1 for 8 cycles, subsequent reads all 0x00. A sel issued during busy is ignored (no valid).
6. Assert rst at cycle 3 of a clear -> outputs return to reset values immediately; after release, ready rises exactly DEPTH cycles later.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and helpers for the synchronous RAM block.
// State encoding, request op codes and a width helper.
package ram_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Address bits needed for n words, never less than one.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1)
      r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ram_array.sv
// Raw storage: one clocked write port, one clocked read port.
// No reset; contents are defined by the clear sequencer above.
module ram_array #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/ram_sync.sv
// Synchronous WIDTH x DEPTH RAM with request handshake,
// registered read port and an automatic clear sequencer.
module ram_sync
  import ram_pkg::*;
#(
  parameter int              WIDTH   = 8,
  parameter int              DEPTH   = 8,
  parameter logic [WIDTH-1:0] CLR_VAL = '0,
  localparam int             ADDR_W  = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  inp,
  input  logic [ADDR_W-1:0] addr,
  input  logic              op,
  input  logic              sel,
  input  logic              clr,
  output logic              ready,
  output logic [WIDTH-1:0]  outp,
  output logic              outp_valid,
  output logic              err,
  output logic              busy
);

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              zero_q;
  logic [WIDTH-1:0]  rdata;

  logic              clearing;
  logic              accept;
  logic              in_range;
  logic              rd_req;
  logic              we;
  logic              re;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;

  assign clearing = (state == ST_CLEAR);
  assign accept   = sel & (state == ST_IDLE);
  assign in_range = {1'b0, addr} < DEPTH_L;
  assign rd_req   = accept & (op == OP_READ);

  // The sequencer owns the write port while clearing.
  assign we    = clearing
               | (accept & (op == OP_WRITE) & in_range);
  assign waddr = clearing ? cnt : addr;
  assign wdata = clearing ? CLR_VAL : inp;
  assign re    = rd_req & in_range;

  ram_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .re   (re),
    .raddr(addr),
    .rdata(rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_CLEAR;
      cnt        <= '0;
      zero_q     <= 1'b1;
      outp_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      outp_valid <= rd_req;
      err        <= accept & ~in_range;
      if (rd_req)
        zero_q <= ~in_range;
      unique case (state)
        ST_CLEAR: begin
          if (cnt == LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        ST_IDLE: begin
          if (clr)
            state <= ST_CLEAR;
        end
      endcase
    end
  end

  // zero_q masks the unreset array output and forces out-of-range reads to 0.
  assign outp  = zero_q ? '0 : rdata;
  assign ready = (state == ST_IDLE);
  assign busy  = (state == ST_CLEAR);

endmodule

// File: tb/tb_ram_sync.sv
// Directed bench for ram_sync: 8x8 and 5x16 instances.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_ram_sync;

  logic clk;
  logic rst;

  logic        sel8, op8, clr8;
  logic [2:0]  addr8;
  logic [7:0]  inp8;
  logic        rdy8, vld8, err8, busy8;
  logic [7:0]  outp8;

  logic        sel5, op5, clr5;
  logic [2:0]  addr5;
  logic [15:0] inp5;
  logic        rdy5, vld5, err5, busy5;
  logic [15:0] outp5;

  int n_vec;
  int n_err;

  ram_sync #(.WIDTH(8), .DEPTH(8)) u8 (
    .clk       (clk),
    .rst       (rst),
    .inp       (inp8),
    .addr      (addr8),
    .op        (op8),
    .sel       (sel8),
    .clr       (clr8),
    .ready     (rdy8),
    .outp      (outp8),
    .outp_valid(vld8),
    .err       (err8),
    .busy      (busy8)
  );

  ram_sync #(.WIDTH(16), .DEPTH(5)) u5 (
    .clk       (clk),
    .rst       (rst),
    .inp       (inp5),
    .addr      (addr5),
    .op        (op5),
    .sel       (sel5),
    .clr       (clr5),
    .ready     (rdy5),
    .outp      (outp5),
    .outp_valid(vld5),
    .err       (err5),
    .busy      (busy5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    sel8 = 0; op8 = 0; clr8 = 0; addr8 = 0; inp8 = 0;
    sel5 = 0; op5 = 0; clr5 = 0; addr5 = 0; inp5 = 0;
    tick();
    tick();

    // 1: reset values, clear length, reads of cleared array
    chk("rst_busy", 32'(busy8), 1);
    chk("rst_ready", 32'(rdy8), 0);
    chk("rst_outp", 32'(outp8), 0);
    chk("rst_valid", 32'(vld8), 0);
    chk("rst_err", 32'(err8), 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("clr_busy", 32'(busy8), 1);
      chk("clr_ready", 32'(rdy8), 0);
      tick();
    end
    chk("clr_done_ready", 32'(rdy8), 1);
    chk("clr_done_busy", 32'(busy8), 0);
    for (int i = 0; i < 8; i++) begin
      sel8 = 1; op8 = 0; addr8 = 3'(i);
      tick();
      chk("init_rd_valid", 32'(vld8), 1);
      chk("init_rd_data", 32'(outp8), 0);
    end
    sel8 = 0;
    tick();
    chk("init_valid_drop", 32'(vld8), 0);

    // 2: write then read-after-write
    sel8 = 1; op8 = 1; addr8 = 3; inp8 = 8'hA5;
    tick();
    chk("raw_wr_valid", 32'(vld8), 0);
    chk("raw_wr_err", 32'(err8), 0);
    op8 = 0; addr8 = 3;
    tick();
    chk("raw_rd3_valid", 32'(vld8), 1);
    chk("raw_rd3_data", 32'(outp8), 32'hA5);
    chk("raw_rd3_err", 32'(err8), 0);
    addr8 = 4;
    tick();
    chk("raw_rd4_valid", 32'(vld8), 1);
    chk("raw_rd4_data", 32'(outp8), 0);
    sel8 = 0;
    tick();
    chk("raw_hold_valid", 32'(vld8), 0);
    chk("raw_hold_data", 32'(outp8), 0);

    // 3: streaming writes then streaming reads
    for (int i = 0; i < 8; i++) begin
      sel8 = 1; op8 = 1; addr8 = 3'(i); inp8 = 8'(i * 17);
      tick();
      chk("str_wr_valid", 32'(vld8), 0);
    end
    for (int i = 0; i < 8; i++) begin
      op8 = 0; addr8 = 3'(i);
      tick();
      chk("str_rd_valid", 32'(vld8), 1);
      chk("str_rd_data", 32'(outp8), 32'(i * 17));
    end
    sel8 = 0;
    tick();

    // 4: out-of-range on the 5-word instance
    for (int i = 0; i < 5; i++) begin
      sel5 = 1; op5 = 1; addr5 = 3'(i); inp5 = 16'(16'h1000 + i);
      tick();
      chk("d5_wr_err", 32'(err5), 0);
    end
    op5 = 0; addr5 = 4;
    tick();
    chk("d5_rd4_data", 32'(outp5), 32'h1004);
    op5 = 1; addr5 = 6; inp5 = 16'hBEEF;
    tick();
    chk("d5_oor_wr_err", 32'(err5), 1);
    chk("d5_oor_wr_valid", 32'(vld5), 0);
    chk("d5_oor_wr_hold", 32'(outp5), 32'h1004);
    op5 = 0; addr5 = 6;
    tick();
    chk("d5_oor_rd_err", 32'(err5), 1);
    chk("d5_oor_rd_valid", 32'(vld5), 1);
    chk("d5_oor_rd_data", 32'(outp5), 0);
    for (int i = 0; i < 5; i++) begin
      addr5 = 3'(i);
      tick();
      chk("d5_chk_err", 32'(err5), 0);
      chk("d5_chk_data", 32'(outp5), 32'(16'h1000 + i));
    end
    sel5 = 0;
    tick();
    chk("d5_err_drop", 32'(err5), 0);

    // 5: clear together with a read, ignored requests while busy
    for (int i = 0; i < 8; i++) begin
      sel8 = 1; op8 = 1; addr8 = 3'(i); inp8 = 8'hFF;
      tick();
    end
    op8 = 0; addr8 = 2; clr8 = 1;
    tick();
    chk("cr_valid", 32'(vld8), 1);
    chk("cr_data", 32'(outp8), 32'hFF);
    chk("cr_busy", 32'(busy8), 1);
    addr8 = 5;
    for (int i = 0; i < 7; i++) begin
      clr8 = (i == 2);
      tick();
      chk("cr_busy_hold", 32'(busy8), 1);
      chk("cr_ignored_valid", 32'(vld8), 0);
      chk("cr_ignored_err", 32'(err8), 0);
    end
    clr8 = 0; sel8 = 0;
    tick();
    chk("cr_done_ready", 32'(rdy8), 1);
    chk("cr_done_busy", 32'(busy8), 0);
    for (int i = 0; i < 8; i++) begin
      sel8 = 1; op8 = 0; addr8 = 3'(i);
      tick();
      chk("cr_rd_data", 32'(outp8), 0);
      chk("cr_rd_valid", 32'(vld8), 1);
    end
    sel8 = 0;

    // 6: reset in the middle of a clear
    sel8 = 1; op8 = 1; addr8 = 1; inp8 = 8'h5A;
    tick();
    op8 = 0; clr8 = 1;
    tick();
    chk("mr_rd_data", 32'(outp8), 32'h5A);
    sel8 = 0; clr8 = 0;
    tick();
    tick();
    chk("mr_pre_busy", 32'(busy8), 1);
    chk("mr_pre_outp", 32'(outp8), 32'h5A);
    #2 rst = 1'b1;
    #1;
    chk("mr_rst_busy", 32'(busy8), 1);
    chk("mr_rst_ready", 32'(rdy8), 0);
    chk("mr_rst_outp", 32'(outp8), 0);
    chk("mr_rst_valid", 32'(vld8), 0);
    chk("mr_rst_err", 32'(err8), 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("mr_clr_ready", 32'(rdy8), 0);
      tick();
    end
    chk("mr_ready", 32'(rdy8), 1);
    sel8 = 1; op8 = 0; addr8 = 1;
    tick();
    chk("mr_rd_cleared", 32'(outp8), 0);
    chk("mr_rd_valid", 32'(vld8), 1);
    sel8 = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
